mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one main-memory port between 2**CTRL requesters, e.g. the icache and dcache refill/writeback paths.
- Holds at most one outstanding transaction.
- Latches the granted requester index and steers the memory response back only to that requester.
- The other requesters see zero on their response outputs.

Parameters:
- CTRL, 1, requester index width; NUM_REQ = 2**CTRL requesters.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 128, line/data width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  1 [NUM_REQ]  requester i has a pending request.
- req_write  input  1 [NUM_REQ]  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH [NUM_REQ]  request address.
- req_wdata  input  DATA_WIDTH [NUM_REQ]  write data.
- req_ready  output  1 [NUM_REQ]  request i accepted this cycle (one-cycle pulse).
- resp_valid  output  1 [NUM_REQ]  response for requester i.
- resp_rdata  output  DATA_WIDTH [NUM_REQ]  read data for requester i; zero when resp_valid[i]=0.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts request.
- mem_req_write  output  1  write flag to memory.
- mem_req_addr  output  ADDR_WIDTH  address to memory.
- mem_req_wdata  output  DATA_WIDTH  write data to memory.
- mem_resp_valid  input  1  memory completion, one-cycle pulse, for both reads and writes.
- mem_resp_rdata  input  DATA_WIDTH  read data, valid with mem_resp_valid.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Registers: state, grant_idx (CTRL bits), last_idx (CTRL bits), latched write/addr/wdata.
- Reset (reset_n=0 at clock edge):
  - state=IDLE, grant_idx=0, last_idx=NUM_REQ-1 so requester 0 has first priority.
  - All req_ready=0, resp_valid=0, resp_rdata=0, mem_req_valid=0; mem_req_write/addr/wdata=0.
  - Reset mid-transaction abandons it; a later mem_resp_valid arriving in IDLE is ignored.
- IDLE:
  - If any req_valid, pick the first asserted index searching last_idx+1, last_idx+2, … modulo NUM_REQ (wrap-around).
  - Set req_ready[sel]=1 for exactly that cycle (combinational, decoded from the selection).
  - Latch write/addr/wdata of sel, set grant_idx=sel, go to ISSUE.
  - No req_valid: stay in IDLE; all req_ready=0.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, go to WAIT.
  - No other requester is accepted in this state.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: resp_valid[grant_idx]=1 and resp_rdata[grant_idx]=mem_resp_rdata, combinationally in the same cycle; all other indices are zero.
  - On the same edge: last_idx=grant_idx, go to IDLE.
- Latency:
  - Grant is in the same cycle req_valid is seen in IDLE.
  - mem_req_valid is asserted the next cycle.
  - Earliest new grant is the cycle after mem_resp_valid.
- Requester rules:
  - A requester must hold req_valid and its fields stable until req_ready.
  - After req_ready, it may deassert or present a new request; a new request competes normally.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,NUM_REQ-1,0,… with no starvation.
- Boundary cases:
  - mem_resp_valid while in IDLE or ISSUE is ignored and no resp_valid is produced.
  - A req_valid deassert during ISSUE/WAIT by a non-granted requester has no effect.
  - CTRL=1 reduces to two-way alternation.

Test Plan:
- Reset, then hold reset_n=0 for 2 cycles with req_valid all 1 -> every req_ready, resp_valid and mem_req_valid is 0; first grant after release goes to index 0.
- Single read: req_valid[1]=1, addr=0x100, memory ready immediately, response 3 cycles later with rdata=0xDEADBEEF -> req_ready[1] pulses once, mem_req_addr=0x100 and mem_req_write=0, then resp_valid[1]=1 with resp_rdata[1]=0xDEADBEEF while resp_valid[0]=0 and resp_rdata[0]=0.
- Back-pressure: mem_req_ready=0 for 5 cycles during a write of wdata=0x55 -> mem_req_valid stays 1 and addr/wdata stay stable for all 5 cycles; transition to WAIT only once mem_req_ready=1.
- Round-robin, CTRL=2, all four req_valid held high -> grant order 0,1,2,3,0; each req_ready pulses exactly once per rotation.
- Wrap and skip: last grant=2, only req_valid[0] and req_valid[1] high -> index 0 is granted (3 skipped, wrap to 0).
- Reset asserted in WAIT, then a stray mem_resp_valid after release -> no resp_valid; the next request proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter that shares one main-memory port between
//            2**CTRL requesters (e.g. icache / dcache refill and writeback).
//            At most one transaction is outstanding. The granted requester
//            index is latched so the memory response is steered back only to
//            the requester that issued it; every other requester sees zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int CTRL       = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,

  // Requester side
  input  logic [2**CTRL-1:0]    req_valid,
  input  logic [2**CTRL-1:0]    req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr   [2**CTRL],
  input  logic [DATA_WIDTH-1:0] req_wdata  [2**CTRL],
  output logic [2**CTRL-1:0]    req_ready,
  output logic [2**CTRL-1:0]    resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata [2**CTRL],

  // Memory side
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

  localparam int NUM_REQ = 2**CTRL;

  // Last requester index; loaded into r_last_idx on reset so that the
  // wrap-around search starts at requester 0.
  localparam logic [CTRL-1:0] c_last_rst = CTRL'(NUM_REQ - 1);

  // IDLE  : waiting for any requester, grant happens combinationally here
  // ISSUE : presenting the latched request to memory until it is accepted
  // WAIT  : request accepted, waiting for the single completion pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [CTRL-1:0]       r_grant_idx;
  logic [CTRL-1:0]       r_last_idx;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_any;
  logic [CTRL-1:0]       w_sel;
  logic                  w_grant;
  logic                  w_resp_hit;

  // Wrap-around priority search starting just after the last served index.
  // The loop runs from the farthest candidate down to the nearest one so the
  // nearest asserted requester is the final (winning) assignment.
  always_comb begin
    logic [CTRL-1:0] cand;
    w_any = 1'b0;
    w_sel = r_last_idx;
    cand  = r_last_idx;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = r_last_idx + CTRL'(k);
      if (req_valid[cand]) begin
        w_any = 1'b1;
        w_sel = cand;
      end
    end
  end

  // Next-state logic plus the grant and response strobes. Both strobes are
  // qualified with reset_n so nothing leaks out while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_resp_hit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant     = reset_n;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_resp_hit  = reset_n;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and transaction latches; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= c_last_rst;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_grant_idx <= w_sel;
        r_write     <= req_write[w_sel];
        r_addr      <= req_addr[w_sel];
        r_wdata     <= req_wdata[w_sel];
      end
      if (w_resp_hit) begin
        r_last_idx <= r_grant_idx;
      end
    end
  end

  // Memory request is driven straight from the latches so it stays stable
  // for as long as memory applies back-pressure.
  assign mem_req_valid = reset_n && (r_state == S_ISSUE);
  assign mem_req_write = r_write;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;

  // Per-requester decode of the grant pulse and the steered response.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
      assign req_ready[i]  = w_grant && (w_sel == CTRL'(i));
      assign resp_valid[i] = w_resp_hit && (r_grant_idx == CTRL'(i));
      assign resp_rdata[i] = resp_valid[i] ? mem_resp_rdata : '0;
    end
  endgenerate

endmodule
`default_nettype wire
